reaction_timer: RTL and testbench
=================================

REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 SHALL have parameter CLK_PER_MS, default 50000: Clock cycles per millisecond tick.
REQ-002 SHALL have parameter MIN_DELAY_MS, default 1000: minimum random wait before Led turns on, in ms.
REQ-003 SHALL have parameter RAND_BITS, default 11: number of LFSR bits added to MIN_DELAY_MS; range 1..11.
REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1: LFSR reset value; non-zero.
REQ-005 SHALL have port Clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port Start, input, 1 bit: start button, already synchronised to Clock; level.
REQ-008 SHALL have port React, input, 1 bit: reaction button, already synchronised to Clock; level.
REQ-009 SHALL have port Led, output, 1 bit: stimulus light; high while the player must react.
REQ-010 SHALL have port Score, output, 13 bits: reaction time in ms, unsigned, feeding the 4-digit score display.
REQ-011 SHALL have port ScoreValid, output, 1 bit: one-cycle pulse when Score is updated.
REQ-012 SHALL have port TooEarly, output, 1 bit: high while in FALSE_START.
REQ-013 SHALL have port Busy, output, 1 bit: high in WAIT and ARMED.

Function
REQ-014 SHALL detect rising edges of Start and React with one registered copy of each; "press" means a rising edge.
REQ-015 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every cycle.
REQ-016 SHALL implement states IDLE, WAIT, ARMED, DONE, FALSE_START.
REQ-017 IDLE/DONE/FALSE_START + Start press SHALL latch delay = MIN_DELAY_MS + lfsr[RAND_BITS-1:0] and go to WAIT next cycle.
REQ-018 WAIT/ARMED SHALL ignore Start presses.
REQ-019 SHALL use a prescaler that counts 0..CLK_PER_MS-1 and emits a ms tick on wrap; it is cleared on every state entry.
REQ-020 WAIT SHALL decrement delay on each ms tick; on the tick that reaches 0 it SHALL enter ARMED and set Led=1 the next cycle, with the ms counter at 0.
REQ-021 ARMED SHALL increment the 13-bit ms counter on each tick and saturate at 8191.
REQ-022 ARMED + React press SHALL load Score with the ms counter, pulse ScoreValid, clear Led and enter DONE, all in the same clock edge.
REQ-023 When React is pressed on the same cycle as a tick, the Score SHALL be the pre-increment value.
REQ-024 ARMED with counter at 8191 on a tick (timeout) SHALL load Score=8191, pulse ScoreValid, clear Led and enter DONE.
REQ-025 Score SHALL hold its value until the next load or Reset; ScoreValid SHALL never last more than one cycle.
REQ-026 DONE SHALL ignore React.

Reset
REQ-027 On Reset high at a Clock edge the block SHALL enter IDLE, with Led=0, Score=0, ScoreValid=0, TooEarly=0, Busy=0, counters=0, LFSR=LFSR_SEED and edge registers=0.
REQ-028 Reset SHALL take priority over all events, including mid-WAIT or mid-ARMED; no ScoreValid is issued.

Configuration
REQ-029 With macro REACTION_TIMER_FALSE_START_EN defined, a React press in WAIT SHALL enter FALSE_START, load Score=8191, pulse ScoreValid and assert TooEarly.
REQ-030 Without REACTION_TIMER_FALSE_START_EN, React in WAIT SHALL be ignored, FALSE_START SHALL be unreachable and TooEarly SHALL be tied 0.

Verification (CLK_PER_MS=4, MIN_DELAY_MS=2, RAND_BITS=1)
REQ-031 Reset, then Start press -> Busy=1; Led rises 8 or 12 cycles after WAIT entry; Score stays 0.
REQ-032 React press 22 cycles after Led rises -> Score=5, one-cycle ScoreValid, Led=0, Busy=0.
REQ-033 No React after Led rises -> after 8192 ticks Score=8191, ScoreValid pulses once, state is DONE.
REQ-034 React press in WAIT with macro defined -> TooEarly=1, Score=8191, ScoreValid pulse; with macro undefined -> no change, Led still rises.
REQ-035 Reset asserted mid-ARMED -> next cycle Led=0, Score=0, Busy=0; a following Start press restarts normally.
REQ-036 Start held high for 50 cycles, or pressed during ARMED -> exactly one WAIT entry; the ARMED timing is unaffected.

Source files
------------

// File: rtl/reaction_timer.sv
// Reaction-time game: random wait, light the LED, time the player's response in ms.
// Optional false-start detection is enabled by defining REACTION_TIMER_FALSE_START_EN.
module reaction_timer #(
   parameter int          CLK_PER_MS   = 50000,
   parameter int          MIN_DELAY_MS = 1000,
   parameter int          RAND_BITS    = 11,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Start,
   input  logic        React,
   output logic        Led,
   output logic [12:0] Score,
   output logic        ScoreValid,
   output logic        TooEarly,
   output logic        Busy
);

   localparam int          PRE_W   = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_PER_MS - 1);
   localparam logic [12:0] CNT_MAX = 13'h1FFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ARMED,
      S_DONE,
      S_FALSE
   } state_t;

   state_t             state_q, state_d;
   logic               start_q, react_q;
   logic [15:0]        lfsr_q, lfsr_d;
   logic [PRE_W-1:0]   pre_q, pre_d;
   logic [15:0]        delay_q, delay_d;
   logic [12:0]        cnt_q, cnt_d;
   logic [12:0]        score_q, score_d;
   logic               sv_q, sv_d;
   logic               start_press, react_press, tick;

   assign start_press = Start & ~start_q;
   assign react_press = React & ~react_q;
   assign tick        = (pre_q == PRE_MAX);

   // Taps 16,14,13,11 in right-shift form: feedback enters at bit 15.
   assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

   always_comb begin
      state_d = state_q;
      pre_d   = tick ? '0 : pre_q + 1'b1;
      delay_d = delay_q;
      cnt_d   = cnt_q;
      score_d = score_q;
      sv_d    = 1'b0;
      case (state_q)
         S_IDLE, S_DONE, S_FALSE: begin
            if (start_press) begin
               delay_d = 16'(MIN_DELAY_MS) + {{(16-RAND_BITS){1'b0}}, lfsr_q[RAND_BITS-1:0]};
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (tick) begin
               if (delay_q <= 16'd1) begin
                  delay_d = '0;
                  state_d = S_ARMED;
               end else begin
                  delay_d = delay_q - 16'd1;
               end
            end
`ifdef REACTION_TIMER_FALSE_START_EN
            if (react_press) begin
               score_d = CNT_MAX;
               sv_d    = 1'b1;
               state_d = S_FALSE;
            end
`endif
         end
         S_ARMED: begin
            // A press on a tick cycle reports the count before that tick.
            if (react_press) begin
               score_d = cnt_q;
               sv_d    = 1'b1;
               state_d = S_DONE;
            end else if (tick) begin
               if (cnt_q == CNT_MAX) begin
                  score_d = CNT_MAX;
                  sv_d    = 1'b1;
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + 13'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d != state_q) begin
         pre_d = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= S_IDLE;
         start_q <= 1'b0;
         react_q <= 1'b0;
         lfsr_q  <= LFSR_SEED;
         pre_q   <= '0;
         delay_q <= '0;
         cnt_q   <= '0;
         score_q <= '0;
         sv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= Start;
         react_q <= React;
         lfsr_q  <= lfsr_d;
         pre_q   <= pre_d;
         delay_q <= delay_d;
         cnt_q   <= cnt_d;
         score_q <= score_d;
         sv_q    <= sv_d;
      end
   end

   assign Led        = (state_q == S_ARMED);
   assign Busy       = (state_q == S_WAIT) || (state_q == S_ARMED);
   assign Score      = score_q;
   assign ScoreValid = sv_q;
`ifdef REACTION_TIMER_FALSE_START_EN
   assign TooEarly   = (state_q == S_FALSE);
`else
   assign TooEarly   = 1'b0;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// Bench for reaction_timer with a 4-cycle ms tick and a 2..3 ms random wait.
module tb_reaction_timer;

   localparam int          CPM  = 4;
   localparam int          MIND = 2;
   localparam int          RB   = 1;
   localparam logic [15:0] SEED = 16'hACE1;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        Start = 1'b0;
   logic        React = 1'b0;
   logic        Led, ScoreValid, TooEarly, Busy;
   logic [12:0] Score;

   int vectors     = 0;
   int miscompares = 0;
   int sv_count    = 0;
   logic [15:0] m_lfsr;

   reaction_timer #(
      .CLK_PER_MS  (CPM),
      .MIN_DELAY_MS(MIND),
      .RAND_BITS   (RB),
      .LFSR_SEED   (SEED)
   ) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Start     (Start),
      .React     (React),
      .Led       (Led),
      .Score     (Score),
      .ScoreValid(ScoreValid),
      .TooEarly  (TooEarly),
      .Busy      (Busy)
   );

   always #5 Clock = ~Clock;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      logic [15:0] b;
      b = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 16'd1;
      return (v >> 1) | (b << 15);
   endfunction

   // Reference LFSR: seed on reset, one step per clock otherwise.
   always @(posedge Clock) m_lfsr <= Reset ? SEED : lfsr_next(m_lfsr);

   always @(negedge Clock) if (ScoreValid === 1'b1) sv_count <= sv_count + 1;

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Press Start; returns the wait (ms) the rules predict from the current LFSR value.
   task automatic start_game(output int d);
      Start = 1'b1;
      d = MIND + int'(m_lfsr & 16'((1 << RB) - 1));
      step();
      Start = 1'b0;
      check("busy_after_start", Busy, 1);
   endtask

   // Waits for Led; n0 cycles of WAIT have already elapsed. Noise only well before Led.
   task automatic wait_led(input int d, input int n0, input bit noise, input string name);
      int n;
      n = n0;
      while (Led !== 1'b1 && n < 100) begin
         if (noise && n < 4*d - 2) begin
            Start = 1'($urandom_range(0, 1));
`ifndef REACTION_TIMER_FALSE_START_EN
            React = 1'($urandom_range(0, 1));
`endif
         end else begin
            Start = 1'b0;
            React = 1'b0;
         end
         step();
         n++;
      end
      Start = 1'b0;
      React = 1'b0;
      check(name, n, 4*d);
   endtask

   // React press lands k cycles after ARMED entry.
   task automatic react_after(input int k);
      repeat (k - 1) step();
      React = 1'b1;
      step();
      React = 1'b0;
   endtask

   task automatic play(input int k, input int exp, input bit noise);
      int d, c0;
      start_game(d);
      wait_led(d, 0, noise, "led_rise_delay");
      c0 = sv_count;
      react_after(k);
      check("score", Score, exp);
      check("score_valid", ScoreValid, 1);
      check("led_off", Led, 0);
      check("busy_off", Busy, 0);
      step();
      check("score_valid_one_cycle", ScoreValid, 0);
      check("score_hold", Score, exp);
      check("sv_pulse_count", sv_count - c0, 1);
      $display("game: wait=%0d ms react_k=%0d score=%0d", d, k, Score);
   endtask

   typedef struct {
      int k;
      int score;
   } vec_t;
   vec_t tbl[7];

   initial begin
      int d, c0, n, t, k;
      bit led_ok;
      tbl[0] = '{1, 0};   tbl[1] = '{4, 0};  tbl[2] = '{5, 1};
      tbl[3] = '{8, 1};   tbl[4] = '{9, 2};  tbl[5] = '{22, 5};
      tbl[6] = '{41, 10};

      step(); step();
      check("rst_led", Led, 0);
      check("rst_score", Score, 0);
      check("rst_sv", ScoreValid, 0);
      check("rst_tooearly", TooEarly, 0);
      check("rst_busy", Busy, 0);
      Reset = 1'b0;
      step();

      foreach (tbl[i]) play(tbl[i].k, tbl[i].score, 1'b0);

      for (int g = 0; g < 20; g++) begin
         repeat ($urandom_range(0, 3)) step();
         k = $urandom_range(1, 80);
         play(k, (k - 1) / 4, 1'b1);
      end

      // Start held for 50 cycles, then a fresh Start press while armed.
      Start = 1'b1;
      d = MIND + int'(m_lfsr & 16'((1 << RB) - 1));
      step();
      n = 0;
      while (Led !== 1'b1 && n < 100) begin step(); n++; end
      check("held_start_led_delay", n, 4*d);
      led_ok = 1'b1;
      t = 0;
      while (n + t < 50) begin
         step(); t++;
         if (Led !== 1'b1 || Busy !== 1'b1) led_ok = 1'b0;
      end
      check("held_start_stays_armed", led_ok, 1);
      Start = 1'b0; step(); t++;
      Start = 1'b1; step(); t++;
      Start = 1'b0;
      check("start_in_armed_ignored", Led, 1);
      c0 = sv_count;
      React = 1'b1; step(); t++;
      React = 1'b0;
      check("held_start_score", Score, (t - 1) / 4);
      check("held_start_sv", ScoreValid, 1);
      step();
      check("held_start_sv_count", sv_count - c0, 1);
      $display("game: held start, react_k=%0d score=%0d", t, Score);

      // Reset in the middle of ARMED, then a normal restart.
      start_game(d);
      wait_led(d, 0, 1'b0, "pre_reset_led_delay");
      c0 = sv_count;
      repeat (10) step();
      Reset = 1'b1; step(); Reset = 1'b0;
      check("mid_armed_rst_led", Led, 0);
      check("mid_armed_rst_score", Score, 0);
      check("mid_armed_rst_busy", Busy, 0);
      check("mid_armed_rst_sv", ScoreValid, 0);
      step();
      check("mid_armed_rst_no_sv", sv_count - c0, 0);
      play(22, 5, 1'b0);

      // Reset in the middle of WAIT.
      start_game(d);
      repeat (3) step();
      c0 = sv_count;
      Reset = 1'b1; step(); Reset = 1'b0;
      check("mid_wait_rst_busy", Busy, 0);
      repeat (15) step();
      check("mid_wait_rst_idle", Led, 0);
      check("mid_wait_rst_no_sv", sv_count - c0, 0);
      $display("reset during wait handled");

      // React during WAIT.
      start_game(d);
      c0 = sv_count;
      step();
      React = 1'b1; step(); React = 1'b0;
`ifdef REACTION_TIMER_FALSE_START_EN
      check("false_start_tooearly", TooEarly, 1);
      check("false_start_score", Score, 8191);
      check("false_start_sv", ScoreValid, 1);
      check("false_start_busy", Busy, 0);
      step();
      check("false_start_sv_one", ScoreValid, 0);
      check("false_start_hold", TooEarly, 1);
      check("false_start_sv_count", sv_count - c0, 1);
      $display("false start: score=%0d", Score);
      play(9, 2, 1'b0);
      check("tooearly_cleared", TooEarly, 0);
`else
      check("early_react_tooearly", TooEarly, 0);
      check("early_react_busy", Busy, 1);
      wait_led(d, 2, 1'b0, "early_react_led_delay");
      check("early_react_no_sv", sv_count - c0, 0);
      react_after(13);
      check("early_react_score", Score, 3);
      step();
      $display("early react ignored, score=%0d", Score);
`endif

      // Timeout: no React after Led rises.
      start_game(d);
      wait_led(d, 0, 1'b0, "timeout_led_delay");
      c0 = sv_count;
      n = 0;
      while (ScoreValid !== 1'b1 && n < 40000) begin step(); n++; end
      check("timeout_cycles", n, 8192 * CPM);
      check("timeout_score", Score, 8191);
      check("timeout_led", Led, 0);
      check("timeout_busy", Busy, 0);
      repeat (3) step();
      React = 1'b1; step(); React = 1'b0;
      repeat (3) step();
      check("timeout_sv_count", sv_count - c0, 1);
      check("done_ignores_react", Score, 8191);
      $display("timeout after %0d cycles, score=%0d", n, Score);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
